// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage plus the IF/ID pipeline register. Owns the PC,
// drives the instruction-memory address, assembles two-word instructions
// (opcode word followed by a 16-bit immediate word) and injects interrupt
// slots at instruction boundaries. Handles stall, branch redirect and flush.
//
// Optional feature macro: FETCH_PERF_CNT_EN
//   When defined, adds o_fetch_count, a 32-bit wrapping count of every edge
//   on which the IF/ID register loads a valid slot (interrupt slots included).
//
// Ports:
//   i_clk            clock, rising edge
//   i_rst_n          asynchronous active-low reset
//   i_stall          hold PC, state and IF/ID register
//   i_branch_taken   redirect PC to i_branch_target and flush
//   i_branch_target  redirect address
//   i_interrupt      external interrupt request (single-cycle pulse)
//   o_imem_addr      instruction-memory address (equals PC)
//   i_imem_data      instruction word read combinationally at o_imem_addr
//   o_instr          IF/ID instruction, opcode in [15:11]
//   o_imm            IF/ID immediate (valid for the two-word opcode only)
//   o_pc             IF/ID PC following the instruction (return address)
//   o_valid          IF/ID holds a real instruction
//   o_interrupt      IF/ID slot is an injected interrupt
//   o_fetch_count    valid-load counter (FETCH_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter int              PC_W       = 32,
    parameter logic [PC_W-1:0] RESET_PC   = '0,
    parameter logic [4:0]      IMM_OPCODE = 5'b10010
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_stall,
    input  logic            i_branch_taken,
    input  logic [PC_W-1:0] i_branch_target,
    input  logic            i_interrupt,
    output logic [PC_W-1:0] o_imem_addr,
    input  logic [15:0]     i_imem_data,
    output logic [15:0]     o_instr,
    output logic [15:0]     o_imm,
    output logic [PC_W-1:0] o_pc,
    output logic            o_valid,
    output logic            o_interrupt
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     o_fetch_count
`endif
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_IMM,
        S_IRQ_WAIT
    } state_t;

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_inc;
    logic            pending;
    logic [15:0]     hold;
    logic            is_imm;
    logic            advance;
    logic            inject;
    logic            load_valid;

    assign o_imem_addr = pc;

    // Natural truncation gives the required modulo-2^PC_W wrap.
    assign pc_inc = pc + {{(PC_W-1){1'b0}}, 1'b1};

    assign is_imm = (i_imem_data[15:11] == IMM_OPCODE);

    // A normal (non-branch, non-stall) edge is the only one that moves the FSM forward.
    assign advance = !i_branch_taken && !i_stall;

    // Interrupts are taken only at an instruction boundary, never between LDM words.
    assign inject = advance && (state == S_FETCH) && pending;

    // IF/ID receives a real slot: interrupt, one-word instruction, or LDM second word.
    assign load_valid = advance &&
                        (((state == S_FETCH) && (pending || !is_imm)) ||
                         (state == S_IMM));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            pending     <= 1'b0;
            hold        <= '0;
            o_instr     <= '0;
            o_imm       <= '0;
            o_pc        <= '0;
            o_valid     <= 1'b0;
            o_interrupt <= 1'b0;
        end else begin
            // Requests are latched on every edge (stall and branch included) and
            // a repeat pulse while one is pending merges into the same injection.
            pending <= inject ? 1'b0 : (pending | i_interrupt);

            if (i_branch_taken) begin
                pc          <= i_branch_target;
                hold        <= '0;
                state       <= S_FETCH;
                o_instr     <= '0;
                o_imm       <= '0;
                o_valid     <= 1'b0;
                o_interrupt <= 1'b0;
            end else if (!i_stall) begin
                case (state)
                    S_FETCH: begin
                        if (pending) begin
                            // The slot carries the PC of the instruction that was not fetched.
                            o_instr     <= '0;
                            o_imm       <= '0;
                            o_pc        <= pc;
                            o_valid     <= 1'b1;
                            o_interrupt <= 1'b1;
                            state       <= S_IRQ_WAIT;
                        end else if (is_imm) begin
                            hold        <= i_imem_data;
                            pc          <= pc_inc;
                            o_instr     <= '0;
                            o_imm       <= '0;
                            o_valid     <= 1'b0;
                            o_interrupt <= 1'b0;
                            state       <= S_IMM;
                        end else begin
                            o_instr     <= i_imem_data;
                            o_imm       <= '0;
                            o_pc        <= pc_inc;
                            o_valid     <= 1'b1;
                            o_interrupt <= 1'b0;
                            pc          <= pc_inc;
                        end
                    end
                    S_IMM: begin
                        o_instr     <= hold;
                        o_imm       <= i_imem_data;
                        o_pc        <= pc_inc;
                        o_valid     <= 1'b1;
                        o_interrupt <= 1'b0;
                        pc          <= pc_inc;
                        state       <= S_FETCH;
                    end
                    S_IRQ_WAIT: begin
                        // Frozen until the control unit redirects to the ISR vector.
                        o_instr     <= '0;
                        o_imm       <= '0;
                        o_valid     <= 1'b0;
                        o_interrupt <= 1'b0;
                    end
                    default: begin
                        state <= S_FETCH;
                    end
                endcase
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_fetch_count <= '0;
        end else if (load_valid) begin
            o_fetch_count <= o_fetch_count + 32'd1;
        end
    end
`else
    // Keeps the load qualifier observable in the base build without a counter.
    logic unused_load_valid;
    assign unused_load_valid = load_valid;
`endif

endmodule
